// File: rtl/adc_ad4003_pkg.sv
// Shared types and constants for the AD4003 multi-lane deserializer.
package adc_ad4003_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } state_e;

  localparam int unsigned AdcDefaultWidth = 18;
  localparam int unsigned FrameCntWidth   = 16;
  localparam int unsigned AdcMinWidth     = 2;

endpackage

// File: rtl/adc_ad4003_ch_sr.sv
// Per-lane MSB-first shift register; word_d_o is the word including the bit on sdo_i.
module adc_ad4003_ch_sr #(
  parameter int unsigned Width = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_i,
  input  logic             sdo_i,
  output logic [Width-1:0] word_d_o
);

  // Stage Width-1 is the parent's capture register, so only Width-1 stages live here.
  logic [Width-2:0] sr_q;

  assign word_d_o = {sr_q, sdo_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (shift_i) begin
      sr_q <= word_d_o[Width-2:0];
    end
  end

endmodule

// File: rtl/adc_ad4003_deser_mc.sv
// AD4003 N-lane frame deserializer with short/long frame detection.
// Define ADC_AD4003_FRAME_CNT_EN to build the good-frame counter on frame_cnt.
module adc_ad4003_deser_mc
  import adc_ad4003_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH = AdcDefaultWidth,
  parameter int unsigned N_CH           = 8
) (
  input  logic                             adc_read_clk,
  input  logic                             rst,
  input  logic                             reader_en_sync,
  input  logic [N_CH-1:0]                  adc_sdo,
  output logic [N_CH*ADC_DATA_WIDTH-1:0]   adc_data,
  output logic                             adc_data_valid,
  output logic                             frame_err,
  output logic [FrameCntWidth-1:0]         frame_cnt
);

  localparam int unsigned W    = ADC_DATA_WIDTH;
  localparam int unsigned CntW = $clog2(W + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(W - 1);

  state_e                state_q;
  logic                  arm_q;
  logic                  hold_err_q;
  logic [CntW-1:0]       cnt_q;
  logic [N_CH*W-1:0]     data_q;
  logic                  valid_q;
  logic                  err_q;

  logic                  shift_en;
  logic                  capture;
  logic [N_CH*W-1:0]     word_all;

  assign shift_en = reader_en_sync &&
                    (((state_q == StIdle) && arm_q) || (state_q == StShift));
  assign capture  = reader_en_sync && (state_q == StShift) && (cnt_q == LastIdx);

  for (genvar g = 0; g < N_CH; g++) begin : gen_lane
    adc_ad4003_ch_sr #(
      .Width(W)
    ) u_sr (
      .clk_i   (adc_read_clk),
      .rst_i   (rst),
      .shift_i (shift_en),
      .sdo_i   (adc_sdo[g]),
      .word_d_o(word_all[g*W +: W])
    );
  end

  always_ff @(posedge adc_read_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      arm_q      <= 1'b0;
      hold_err_q <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!reader_en_sync) begin
        arm_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (arm_q && reader_en_sync) begin
            arm_q   <= 1'b0;
            cnt_q   <= CntW'(1);
            state_q <= StShift;
          end
        end
        StShift: begin
          if (reader_en_sync) begin
            cnt_q <= cnt_q + 1'b1;
            if (capture) begin
              data_q     <= word_all;
              valid_q    <= 1'b1;
              hold_err_q <= 1'b0;
              state_q    <= StHold;
            end
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StHold: begin
          if (reader_en_sync) begin
            if (!hold_err_q) begin
              err_q      <= 1'b1;
              hold_err_q <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_data       = data_q;
  assign adc_data_valid = valid_q;
  assign frame_err      = err_q;

`ifdef ADC_AD4003_FRAME_CNT_EN
  logic [FrameCntWidth-1:0] frame_cnt_q;

  always_ff @(posedge adc_read_clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (capture) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_ad4003_deser_mc.sv
// Self-checking bench for adc_ad4003_deser_mc (W=18, two lanes).
module tb_adc_ad4003_deser_mc;

  localparam int W = 18;
  localparam int N = 2;
`ifdef ADC_AD4003_FRAME_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [N-1:0]    sdo = '0;
  logic [N*W-1:0]  adc_data;
  logic            adc_data_valid;
  logic            frame_err;
  logic [15:0]     frame_cnt;

  adc_ad4003_deser_mc #(
    .ADC_DATA_WIDTH(W),
    .N_CH          (N)
  ) dut (
    .adc_read_clk  (clk),
    .rst           (rst),
    .reader_en_sync(en),
    .adc_sdo       (sdo),
    .adc_data      (adc_data),
    .adc_data_valid(adc_data_valid),
    .frame_err     (frame_err),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: samples outputs mid-cycle.
  int valid_cnt = 0;
  int err_cnt   = 0;
  int vcyc[$];
  always @(negedge clk) begin
    if (adc_data_valid) begin
      valid_cnt++;
      vcyc.push_back(cyc);
    end
    if (frame_err) err_cnt++;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state: last delivered word per lane and good-frame count.
  logic [W-1:0] m_data[N];
  logic [15:0]  m_cnt;

  typedef struct {
    string        name;
    int           len;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    bit           exp_valid;
    bit           exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en  = 1'b0;
    sdo = N'($urandom);
    repeat (n) tick();
  endtask

  task automatic run_frame(input string name, input int len, input logic [W-1:0] w0,
                           input logic [W-1:0] w1, input int gap, input bit exp_v,
                           input bit exp_e);
    int v0, e0, q0, last_cyc;
    v0 = valid_cnt;
    e0 = err_cnt;
    q0 = vcyc.size();
    last_cyc = -1;
    for (int i = 0; i < len; i++) begin
      en = 1'b1;
      if (i < W) begin
        sdo[0] = w0[W-1-i];
        sdo[1] = w1[W-1-i];
      end else begin
        sdo = N'($urandom);
      end
      tick();
      if (i == W - 1) last_cyc = cyc;
    end
    idle(gap);
    if (len >= W) begin
      m_data[0] = w0;
      m_data[1] = w1;
      if (CntEn) m_cnt = m_cnt + 16'd1;
    end
    chk({name, " valid"}, 64'(valid_cnt - v0), 64'(exp_v));
    chk({name, " err"}, 64'(err_cnt - e0), 64'(exp_e));
    chk({name, " data"}, 64'(adc_data), 64'({m_data[1], m_data[0]}));
    chk({name, " cnt"}, 64'(frame_cnt), 64'(m_cnt));
    if (exp_v && vcyc.size() > q0) chk({name, " latency"}, 64'(vcyc[q0]), 64'(last_cyc));
  endtask

  initial begin
    int v0, e0, q0, len;
    logic [W-1:0] r0, r1;

    m_data[0] = '0;
    m_data[1] = '0;
    m_cnt     = '0;

    vecs[0] = '{"good",    18, 18'h2AAAA, 18'h1FFFF, 1'b1, 1'b0};
    vecs[1] = '{"short10", 10, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1};
    vecs[2] = '{"long20",  20, 18'h00001, 18'h15555, 1'b1, 1'b1};
    vecs[3] = '{"zeros",   18, 18'h00000, 18'h00000, 1'b1, 1'b0};
    vecs[4] = '{"ones",    18, 18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0};
    vecs[5] = '{"short1",   1, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1};
    vecs[6] = '{"short17", 17, 18'h3FFFF, 18'h20001, 1'b0, 1'b1};
    vecs[7] = '{"long19",  19, 18'h12345, 18'h0ABCD, 1'b1, 1'b1};

    // Reset state; enable high at release must not start a frame.
    en = 1'b1;
    repeat (3) tick();
    chk("rst data", 64'(adc_data), 64'd0);
    chk("rst valid", 64'(adc_data_valid), 64'd0);
    chk("rst err", 64'(frame_err), 64'd0);
    chk("rst cnt", 64'(frame_cnt), 64'd0);
    v0 = valid_cnt;
    e0 = err_cnt;
    rst = 1'b0;
    sdo = '1;
    repeat (25) tick();
    chk("noarm valid", 64'(valid_cnt - v0), 64'd0);
    chk("noarm err", 64'(err_cnt - e0), 64'd0);
    idle(2);

    foreach (vecs[i]) begin
      run_frame(vecs[i].name, vecs[i].len, vecs[i].w0, vecs[i].w1, 2,
                vecs[i].exp_valid, vecs[i].exp_err);
    end

    // Back-to-back frames with a single low cycle between them.
    q0 = vcyc.size();
    run_frame("b2b1", 18, 18'h0F0F0, 18'h30303, 1, 1'b1, 1'b0);
    run_frame("b2b2", 18, 18'h1C3C3, 18'h05A5A, 2, 1'b1, 1'b0);
    if (vcyc.size() >= q0 + 2) chk("b2b spacing", 64'(vcyc[q0+1] - vcyc[q0]), 64'd19);
    else chk("b2b pulses", 64'(vcyc.size() - q0), 64'd2);

    // Randomized frames against the rule-based model.
    for (int k = 0; k < 24; k++) begin
      len = int'($urandom_range(1, 22));
      r0  = W'($urandom);
      r1  = W'($urandom);
      run_frame("rand", len, r0, r1, 2, len >= W, len != W);
    end

    // Reset asserted on bit 9, released with enable still high.
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 9; i++) begin
      en  = 1'b1;
      sdo = N'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (25) tick();
    m_data[0] = '0;
    m_data[1] = '0;
    m_cnt     = '0;
    chk("midrst data", 64'(adc_data), 64'd0);
    chk("midrst cnt", 64'(frame_cnt), 64'd0);
    chk("midrst valid", 64'(valid_cnt - v0), 64'd0);
    chk("midrst err", 64'(err_cnt - e0), 64'd0);
    idle(2);
    run_frame("postrst", 18, 18'h2468A, 18'h13579, 2, 1'b1, 1'b0);

    // Counter wrap.
`ifdef ADC_AD4003_FRAME_CNT_EN
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
`endif
    run_frame("wrap", 18, 18'h3C3C3, 18'h00FF0, 2, 1'b1, 1'b0);
    chk("wrap zero", 64'(frame_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_ad4003_deser_mc.md
ADC_AD4003_DESER_MC -- requirements
Module: adc_ad4003_deser_mc

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 18, meaning bits per conversion word (legal range 2..32).
REQ-002 SHALL have parameter N_CH, default 8, meaning number of parallel SDO lanes.
REQ-003 SHALL have port adc_read_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port reader_en_sync  input  1  frame enable, high during exactly the bit cells of one conversion.
REQ-006 SHALL have port adc_sdo  input  N_CH  serial data, one bit per channel, MSB first.
REQ-007 SHALL have port adc_data  output  N_CH*ADC_DATA_WIDTH  last complete word per channel; channel c occupies bits [c*W +: W].
REQ-008 SHALL have port adc_data_valid  output  1  one-cycle pulse when adc_data updates.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on short or long frame.
REQ-010 SHALL have port frame_cnt  output  16  count of good frames.

Function
REQ-011 SHALL implement states IDLE, SHIFT, HOLD, plus an internal arm flag.
REQ-012 SHALL set arm when reader_en_sync is sampled low; a frame may start only when arm is set.
REQ-013 SHALL, in IDLE with arm=1 and reader_en_sync=1, sample bit 0 on that same edge, clear the bit counter to 1 and go to SHIFT.
REQ-014 SHALL, in SHIFT, shift each lane MSB-first (new bit enters LSB, older bits move toward MSB) and increment the bit counter on every edge with reader_en_sync=1.
REQ-015 SHALL, on the edge sampling bit W-1, load adc_data with the W-bit words including that bit, pulse adc_data_valid for exactly the following cycle, and go to HOLD.
REQ-016 SHALL provide zero added latency: adc_data and adc_data_valid become visible after the edge that samples the last bit.
REQ-017 SHALL, if reader_en_sync goes low in SHIFT before W bits are received, discard the partial word, leave adc_data unchanged, pulse frame_err, and go to IDLE.
REQ-018 SHALL, in HOLD, ignore adc_sdo; on the first cycle with reader_en_sync still high, pulse frame_err once, without altering the word already delivered.
REQ-019 SHALL leave HOLD for IDLE on the first cycle with reader_en_sync low; back-to-back frames therefore require at least one low cycle.
REQ-020 SHALL hold adc_data stable between valid pulses.
REQ-021 SHALL increment frame_cnt by 1 on each adc_data_valid pulse, wrapping 0xFFFF to 0x0000.

Reset
REQ-022 SHALL, with rst=1 at an edge, set state IDLE, arm=0, bit counter 0, all shift registers 0, adc_data 0, adc_data_valid 0, frame_err 0, frame_cnt 0.
REQ-023 SHALL, when reset is applied mid-frame, discard the partial frame and produce no valid pulse or error pulse.
REQ-024 SHALL not start a frame if reader_en_sync is high when rst deasserts; reader_en_sync must first be seen low (arm).

Configuration
REQ-025 SHALL, with macro ADC_AD4003_FRAME_CNT_EN defined, implement frame_cnt as in REQ-021.
REQ-026 SHALL, without ADC_AD4003_FRAME_CNT_EN, tie frame_cnt to 0 and include no counter logic; all other behaviour is unchanged.

Structure
REQ-027 SHALL place the state enum typedef, the default width (18), the frame_cnt width (16) and the minimum width (2) in shared package adc_ad4003_pkg.
REQ-028 SHALL instantiate N_CH copies of sub-module adc_ad4003_ch_sr, one W-bit shift register with shift enable per lane, via generate; the FSM, counters and output registers stay in the top module.

Verification
REQ-029 SHALL verify a good frame (W=18, N_CH=2): drive 18 enable cycles with ch0=0x2AAAA, ch1=0x1FFFF -> adc_data={0x1FFFF,0x2AAAA}, one valid pulse after the 18th edge, frame_cnt=1.
REQ-030 SHALL verify a short frame: enable for 10 cycles -> frame_err pulse, no valid pulse, adc_data unchanged, frame_cnt unchanged.
REQ-031 SHALL verify a long frame: enable for 20 cycles with ch0=0x00001 -> valid after bit 18, a single frame_err pulse, adc_data ch0=0x00001.
REQ-032 SHALL verify reset handling: rst asserted at bit 9 and released with enable still high -> all outputs 0 and no frame accepted until enable goes low and then high again.
REQ-033 SHALL verify back-to-back frames: two frames separated by one low cycle -> two valid pulses, 19 cycles apart, frame_cnt=2 (0 when the macro is undefined).
REQ-034 SHALL verify counter wrap: preload frame_cnt to 0xFFFF by force, send one good frame -> frame_cnt=0x0000.
